// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable
// data width, parity and stop bits.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BAUD_W-1:0]           baud_div,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_latch,
    output logic                        tx_full,
    output logic                        tx_empty,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic                        tx_overflow,
    input  logic                        ovf_clear,
    output logic                        tx_out
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;

    state_t state, state_n;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 push, pop, fifo_empty;
    logic [DATA_BITS-1:0] head;

    logic [BAUD_W-1:0]    div_q, baud_cnt, div_eff;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en, par_bit, two_q;
    logic                 tick, last_data, last_stop;
    logic                 line_n, busy_q;

    assign tx_level   = wr_ptr - rd_ptr;
    assign tx_full    = tx_level == (AW+1)'(FIFO_DEPTH);
    assign fifo_empty = wr_ptr == rd_ptr;
    assign push       = tx_latch && !tx_full;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign div_eff    = (baud_div == '0) ? BAUD_W'(1) : baud_div;
    assign tick       = baud_cnt == '0;
    assign last_data  = bit_cnt == 4'(DATA_BITS - 1);
    assign last_stop  = bit_cnt == {3'b000, two_q};

    assign pop = !fifo_empty &&
                 (state == IDLE ||
                  (state == STOP && tick && last_stop));

    // busy_q covers the cycle the registered line lags the FSM
    assign tx_empty = fifo_empty && state == IDLE && !busy_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (tx_latch && tx_full) tx_overflow <= 1'b1;
            else if (ovf_clear)      tx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (!fifo_empty) state_n = START;
            START:  if (tick) state_n = DATA;
            DATA:   if (tick && last_data)
                        state_n = par_en ? PARITY : STOP;
            PARITY: if (tick) state_n = STOP;
            STOP:   if (tick && last_stop)
                        state_n = fifo_empty ? IDLE : START;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_en   <= 1'b0;
            two_q    <= 1'b0;
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (pop) begin
            shreg    <= head;
            par_bit  <= (^head) ^ (parity_mode == 2'b10);
            par_en   <= parity_mode == 2'b01 ||
                        parity_mode == 2'b10;
            two_q    <= two_stop;
            div_q    <= div_eff;
            baud_cnt <= div_eff;
            bit_cnt  <= '0;
        end else if (state != IDLE) begin
            if (tick) begin
                baud_cnt <= div_q;
                bit_cnt  <= (state_n != state) ?
                            4'd0 : bit_cnt + 4'd1;
                if (state == DATA) shreg <= shreg >> 1;
            end else begin
                baud_cnt <= baud_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        line_n = 1'b1;
        unique case (state)
            START:   line_n = 1'b0;
            DATA:    line_n = shreg[0];
            PARITY:  line_n = par_bit;
            default: line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_out <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            tx_out <= line_n;
            busy_q <= state != IDLE;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a
// frame-level reference model.
module tb_uart_tx_fifo;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int BW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [BW-1:0] baud_div = 16'd3;
    logic [1:0]    parity_mode = 2'b00;
    logic          two_stop = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_latch = 1'b0;
    logic          tx_full, tx_empty, tx_overflow, tx_out;
    logic [4:0]    tx_level;
    logic          ovf_clear = 1'b0;

    uart_tx_fifo #(
        .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .BAUD_W(BW)
    ) dut (
        .clk(clk), .reset(reset), .baud_div(baud_div),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .tx_data(tx_data), .tx_latch(tx_latch),
        .tx_full(tx_full), .tx_empty(tx_empty),
        .tx_level(tx_level), .tx_overflow(tx_overflow),
        .ovf_clear(ovf_clear), .tx_out(tx_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          n;
        int          per;
        bit          ce;
        bit          b2b;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b1;

    task automatic check(input string name, input int got,
                         input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, got, want);
        end
    endtask

    // Expected line bits from the current bench configuration
    function automatic exp_t mk(input logic [7:0] d,
                                input bit ce, input bit b2b);
        exp_t e;
        int   k;
        int   ones;
        bit   pb;
        e.bits = '1;
        e.ce   = ce;
        e.b2b  = b2b;
        e.per  = (baud_div == 0 ? 1 : int'(baud_div)) + 1;
        e.bits[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            e.bits[1+i] = d[i];
            ones += int'(d[i]);
        end
        k = 9;
        if (parity_mode == 2'b01 || parity_mode == 2'b10) begin
            pb = (ones % 2) == 1;
            if (parity_mode == 2'b10) pb = !pb;
            e.bits[k] = pb;
            k++;
        end
        e.n = k + 1 + int'(two_stop);
        return e;
    endfunction

    task automatic push(input logic [7:0] d, input bit ce,
                        input bit b2b);
        @(negedge clk);
        tx_data  = d;
        tx_latch = 1'b1;
        expq.push_back(mk(d, ce, b2b));
        @(negedge clk);
        tx_latch = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(tx_empty && expq.size() == 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", int'(t < 20000), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        int   gap;
        bit   ok;
        gap = 0;
        forever begin
            @(negedge clk);
            if (!mon_on || tx_out) begin
                gap++;
                continue;
            end
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got start bit, expected idle");
                for (int w = 0; w < 200 && !tx_out; w++)
                    @(negedge clk);
                continue;
            end
            e = expq.pop_front();
            if (e.b2b) check("b2b_gap", gap, 0);
            ok = 1'b1;
            for (int b = 0; b < e.n; b++) begin
                for (int k = 0; k < e.per; k++) begin
                    if (b != 0 || k != 0) @(negedge clk);
                    if (tx_out !== e.bits[b]) ok = 1'b0;
                end
            end
            check("frame_bits", int'(ok), 1);
            if (e.ce) begin
                check("empty_last_stop", int'(tx_empty), 0);
                @(negedge clk);
                check("empty_after_frame", int'(tx_empty), 1);
            end
            gap = 0;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        tx_latch = 1'b1;
        tx_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_tx_out", int'(tx_out), 1);
        check("rst_full", int'(tx_full), 0);
        check("rst_empty", int'(tx_empty), 1);
        check("rst_level", int'(tx_level), 0);
        check("rst_ovf", int'(tx_overflow), 0);
        expq.push_back(mk(8'hA5, 1'b0, 1'b0));
        reset = 1'b1;
        @(negedge clk);
        tx_latch = 1'b0;
        check("first_push_level", int'(tx_level), 1);
        check("first_push_empty", int'(tx_empty), 0);
        wait_idle();

        push(8'h55, 1'b1, 1'b0);
        @(negedge clk);
        check("line_high_1edge", int'(tx_out), 1);
        @(negedge clk);
        check("line_low_2edge", int'(tx_out), 0);
        wait_idle();

        baud_div = 16'd1;
        parity_mode = 2'b01;
        two_stop = 1'b1;
        push(8'h07, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("even_parity_bit", int'(tx_out), 1);
        wait_idle();
        parity_mode = 2'b10;
        push(8'h07, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("odd_parity_bit", int'(tx_out), 0);
        wait_idle();

        parity_mode = 2'b00;
        two_stop = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            tx_data  = 8'(8'h30 + i);
            tx_latch = 1'b1;
            expq.push_back(mk(tx_data, 1'b0, i > 0));
        end
        @(negedge clk);
        check("burst_full", int'(tx_full), 1);
        check("burst_level", int'(tx_level), 16);
        check("burst_no_ovf", int'(tx_overflow), 0);
        tx_data = 8'hEE;
        @(negedge clk);
        tx_latch = 1'b0;
        check("drop_ovf", int'(tx_overflow), 1);
        check("drop_level", int'(tx_level), 16);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        check("ovf_cleared", int'(tx_overflow), 0);
        wait_idle();

        baud_div = 16'd3;
        push(8'hA3, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        baud_div = 16'd7;
        push(8'h5C, 1'b0, 1'b1);
        wait_idle();

        for (int it = 0; it < 6; it++) begin
            baud_div    = 16'($urandom_range(0, 3));
            parity_mode = 2'($urandom_range(0, 3));
            two_stop    = 1'($urandom_range(0, 1));
            for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push(8'($urandom), 1'b0, 1'b0);
            end
            wait_idle();
        end

        mon_on = 1'b0;
        baud_div = 16'd3;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_latch = 1'b1;
        @(negedge clk);
        tx_data  = 8'h81;
        @(negedge clk);
        tx_latch = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_level", int'(tx_level), 1);
        check("pre_reset_line", int'(tx_out), 0);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_tx_out", int'(tx_out), 1);
        check("mid_rst_level", int'(tx_level), 0);
        check("mid_rst_empty", int'(tx_empty), 1);
        @(negedge clk);
        reset = 1'b1;
        mon_on = 1'b1;
        repeat (80) @(negedge clk);
        check("post_rst_empty", int'(tx_empty), 1);
        check("post_rst_level", int'(tx_level), 0);
        check("queue_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
